// File: rtl/vram_fetch_pkg.sv
// vram_fetch_pkg: shared state type and default widths for the VRAM line fetcher
package vram_fetch_pkg;
  localparam int VRAM_DATA_W = 8;
  localparam int DEF_ADDR_W = 14;
  localparam int DEF_LEN_W = 8;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous byte FIFO with flush and a combinational head (zero when empty)
module fetch_fifo
  import vram_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = VRAM_DATA_W,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          i_clock,
  input  logic          i_reset_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_data,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_full
);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic w_push, w_pop;
  assign w_push = i_push & ~i_flush;
  assign w_pop = i_pop & ~i_flush & ~o_empty;
  assign o_empty = r_count == '0;
  assign o_full = r_count == CW'(DEPTH);
  assign o_count = r_count;
  assign o_data = o_empty ? '0 : r_mem[r_rd];
  // storage write; contents need no reset because the head is masked when empty
  always_ff @(posedge i_clock)
    if (w_push) r_mem[r_wr] <= i_data;
  // pointers and occupancy; flush wins over push and pop
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
endmodule

// File: rtl/vram_line_fetch.sv
// vram_line_fetch: burst byte reader for VRAM port B feeding a valid/ready stream; VRAM_FETCH_ABORT_EN adds i_abort
module vram_line_fetch
  import vram_fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int DEPTH = 4
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
`ifdef VRAM_FETCH_ABORT_EN
  input  logic                   i_abort,
`endif
  input  logic                   i_start,
  input  logic [ADDR_W-1:0]      i_base_addr,
  input  logic [LEN_W-1:0]       i_length,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_ram_enable,
  output logic [ADDR_W-1:0]      o_ram_address,
  input  logic [VRAM_DATA_W-1:0] i_ram_q,
  output logic                   o_out_valid,
  output logic [VRAM_DATA_W-1:0] o_out_data,
  input  logic                   i_out_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_t r_state;
  logic r_busy, r_done, r_ram_en, r_cap;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0] r_issue_cnt, r_pop_cnt;
  logic [CW-1:0] w_count;
  logic [CW:0] w_need;
  logic w_empty, w_full, w_pop, w_room, w_issue, w_abort;
`ifdef VRAM_FETCH_ABORT_EN
  assign w_abort = i_abort && r_state != IDLE;
`else
  assign w_abort = 1'b0;
`endif
  // reads already strobed (r_ram_en) or returning (r_cap) still need a FIFO slot
  assign w_need = {1'b0, w_count} + (CW+1)'(r_cap) + (CW+1)'(r_ram_en) + (CW+1)'(1);
  assign w_room = w_need <= (CW+1)'(DEPTH);
  assign w_issue = r_state == ISSUE && r_issue_cnt != '0 && w_room;
  assign w_pop = !w_empty && i_out_ready;
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_ram_enable = r_ram_en;
  assign o_ram_address = r_addr;
  assign o_out_valid = !w_empty;
  fetch_fifo #(.DEPTH(DEPTH), .W(VRAM_DATA_W)) u_fifo (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_push   (r_cap),
    .i_pop    (w_pop),
    .i_flush  (w_abort),
    .i_data   (i_ram_q),
    .o_data   (o_out_data),
    .o_count  (w_count),
    .o_empty  (w_empty),
    .o_full   (w_full)
  );
  // burst FSM: the start edge already strobes the first read so data lands one cycle later
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_ram_en <= 1'b0;
      r_cap <= 1'b0;
      r_addr <= '0;
      r_issue_cnt <= '0;
      r_pop_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      r_cap <= r_ram_en & ~w_abort;
      if (r_ram_en) r_addr <= r_addr + ADDR_W'(1);
      if (w_abort) begin
        r_state <= IDLE;
        r_busy <= 1'b0;
        r_ram_en <= 1'b0;
        r_issue_cnt <= '0;
        r_pop_cnt <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_ram_en <= 1'b0;
            if (i_start && i_length == '0) r_done <= 1'b1;
            else if (i_start) begin
              r_state <= i_length == LEN_W'(1) ? DRAIN : ISSUE;
              r_busy <= 1'b1;
              r_ram_en <= 1'b1;
              r_addr <= i_base_addr;
              r_issue_cnt <= i_length - LEN_W'(1);
              r_pop_cnt <= i_length;
            end
          end
          ISSUE: begin
            r_ram_en <= w_issue;
            if (w_issue) r_issue_cnt <= r_issue_cnt - LEN_W'(1);
            if (w_issue && r_issue_cnt == LEN_W'(1)) r_state <= DRAIN;
            if (w_pop) r_pop_cnt <= r_pop_cnt - LEN_W'(1);
          end
          DRAIN: begin
            r_ram_en <= 1'b0;
            if (w_pop) r_pop_cnt <= r_pop_cnt - LEN_W'(1);
            if (w_pop && r_pop_cnt == LEN_W'(1)) begin
              r_state <= IDLE;
              r_busy <= 1'b0;
              r_done <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  a_no_overflow: assert property (@(posedge i_clock) disable iff (!i_reset_n) !(r_cap && w_full && !w_pop));
endmodule

// File: tb/tb_vram_line_fetch.sv
// tb_vram_line_fetch: directed checks of the VRAM line fetcher against a byte-address RAM model
module tb_vram_line_fetch;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b1, abort = 1'b0;
  logic [13:0] base = '0;
  logic [7:0] len = '0;
  logic busy, done, ram_en, out_valid;
  logic [13:0] ram_addr;
  logic [7:0] ram_q = '0;
  logic [7:0] out_data;
  int checks = 0, errors = 0, n_done = 0, d0 = 0, n = 0;
  logic [13:0] addr_q[$];
  logic [7:0] data_q[$];
  logic [13:0] wrap_a [4] = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
  logic [7:0] wrap_d [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

  always #5 clk = ~clk;

  vram_line_fetch dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
`ifdef VRAM_FETCH_ABORT_EN
    .i_abort      (abort),
`endif
    .i_start      (start),
    .i_base_addr  (base),
    .i_length     (len),
    .o_busy       (busy),
    .o_done       (done),
    .o_ram_enable (ram_en),
    .o_ram_address(ram_addr),
    .i_ram_q      (ram_q),
    .o_out_valid  (out_valid),
    .o_out_data   (out_data),
    .i_out_ready  (out_ready)
  );

  always @(posedge clk) if (ram_en) ram_q <= ram_addr[7:0];

  always @(negedge clk) if (rst_n) begin
    if (ram_en) addr_q.push_back(ram_addr);
    if (out_valid && out_ready) data_q.push_back(out_data);
    if (done) n_done++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs;
    addr_q.delete();
    data_q.delete();
    d0 = n_done;
  endtask

  task automatic start_burst(input logic [13:0] b, input logic [7:0] l);
    start = 1'b1;
    base = b;
    len = l;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k = 0;
    while (done !== 1'b1 && k < limit) begin
      tick;
      k++;
    end
    check({tag, " done"}, 32'(done), 1);
    tick;
  endtask

  task automatic basic_burst(input string tag);
    out_ready = 1'b1;
    clear_logs;
    start_burst(14'h0100, 8'd4);
    check({tag, " c1 en"}, 32'(ram_en), 1);
    check({tag, " c1 addr"}, 32'(ram_addr), 32'h100);
    check({tag, " c1 busy"}, 32'(busy), 1);
    check({tag, " c1 valid"}, 32'(out_valid), 0);
    tick;
    check({tag, " c2 addr"}, 32'(ram_addr), 32'h101);
    check({tag, " c2 valid"}, 32'(out_valid), 0);
    tick;
    check({tag, " c3 valid"}, 32'(out_valid), 1);
    check({tag, " c3 data"}, 32'(out_data), 32'h00);
    check({tag, " c3 addr"}, 32'(ram_addr), 32'h102);
    tick;
    check({tag, " c4 data"}, 32'(out_data), 32'h01);
    check({tag, " c4 addr"}, 32'(ram_addr), 32'h103);
    check({tag, " c4 en"}, 32'(ram_en), 1);
    tick;
    check({tag, " c5 data"}, 32'(out_data), 32'h02);
    check({tag, " c5 en"}, 32'(ram_en), 0);
    tick;
    check({tag, " c6 data"}, 32'(out_data), 32'h03);
    check({tag, " c6 done"}, 32'(done), 0);
    check({tag, " c6 busy"}, 32'(busy), 1);
    tick;
    check({tag, " c7 done"}, 32'(done), 1);
    check({tag, " c7 busy"}, 32'(busy), 0);
    check({tag, " c7 valid"}, 32'(out_valid), 0);
    tick;
    check({tag, " c8 done"}, 32'(done), 0);
    check({tag, " reads"}, 32'(addr_q.size()), 4);
    check({tag, " bytes"}, 32'(data_q.size()), 4);
    check({tag, " done count"}, 32'(n_done - d0), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick;
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset en", 32'(ram_en), 0);
    check("reset addr", 32'(ram_addr), 0);
    check("reset valid", 32'(out_valid), 0);
    check("reset data", 32'(out_data), 0);
    rst_n = 1'b1;
    tick;
    basic_burst("basic");
    out_ready = 1'b0;
    clear_logs;
    start_burst(14'h0200, 8'd10);
    repeat (11) tick;
    check("bp reads", 32'(addr_q.size()), 4);
    check("bp en", 32'(ram_en), 0);
    check("bp valid", 32'(out_valid), 1);
    check("bp head", 32'(out_data), 32'h00);
    check("bp busy", 32'(busy), 1);
    out_ready = 1'b1;
    wait_done("bp", 200);
    check("bp total reads", 32'(addr_q.size()), 10);
    check("bp bytes", 32'(data_q.size()), 10);
    for (int i = 0; i < 10; i++) check($sformatf("bp byte%0d", i), 32'(data_q[i]), 32'(i));
    check("bp done count", 32'(n_done - d0), 1);
    clear_logs;
    start_burst(14'h3FFE, 8'd4);
    wait_done("wrap", 50);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wrap addr%0d", i), 32'(addr_q[i]), 32'(wrap_a[i]));
      check($sformatf("wrap data%0d", i), 32'(data_q[i]), 32'(wrap_d[i]));
    end
    clear_logs;
    start_burst(14'h0123, 8'd0);
    check("zero done", 32'(done), 1);
    check("zero busy", 32'(busy), 0);
    check("zero en", 32'(ram_en), 0);
    tick;
    check("zero done pulse", 32'(done), 0);
    check("zero reads", 32'(addr_q.size()), 0);
    clear_logs;
    start_burst(14'h0300, 8'd6);
    tick;
    start_burst(14'h1000, 8'd5);
    wait_done("ign", 50);
    check("ign reads", 32'(addr_q.size()), 6);
    check("ign last addr", 32'(addr_q[5]), 32'h305);
    check("ign bytes", 32'(data_q.size()), 6);
    check("ign last byte", 32'(data_q[5]), 32'h05);
    check("ign done count", 32'(n_done - d0), 1);
    check("ign idle", 32'(busy), 0);
    clear_logs;
    start_burst(14'h0100, 8'd8);
    n = 0;
    while (data_q.size() < 2 && n < 20) begin
      tick;
      n++;
    end
    check("rst popped", 32'(data_q.size()), 2);
    d0 = n_done;
    rst_n = 1'b0;
    #1;
    check("rst busy", 32'(busy), 0);
    check("rst en", 32'(ram_en), 0);
    check("rst addr", 32'(ram_addr), 0);
    check("rst valid", 32'(out_valid), 0);
    check("rst data", 32'(out_data), 0);
    repeat (3) tick;
    check("rst hold done", 32'(done), 0);
    rst_n = 1'b1;
    tick;
    check("rst no done", 32'(n_done - d0), 0);
    check("rst idle", 32'(busy), 0);
    basic_burst("post rst");
`ifdef VRAM_FETCH_ABORT_EN
    out_ready = 1'b0;
    clear_logs;
    start_burst(14'h0400, 8'd8);
    tick;
    tick;
    check("abt third read", 32'(ram_en), 1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("abt valid", 32'(out_valid), 0);
    check("abt busy", 32'(busy), 0);
    check("abt en", 32'(ram_en), 0);
    check("abt done", 32'(done), 0);
    addr_q.delete();
    repeat (10) tick;
    check("abt no reads", 32'(addr_q.size()), 0);
    check("abt no done", 32'(n_done - d0), 0);
    check("abt empty", 32'(out_valid), 0);
    out_ready = 1'b1;
    clear_logs;
    start_burst(14'h0500, 8'd3);
    wait_done("abt next", 50);
    check("abt next bytes", 32'(data_q.size()), 3);
    for (int i = 0; i < 3; i++) check($sformatf("abt next byte%0d", i), 32'(data_q[i]), 32'(i));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
